instruction_stack: RTL and testbench

INSTRUCTION_STACK -- requirements
Module: instruction_stack

---
 rtl/instruction_stack.sv | 85 ++++++++
 tb/tb_instruction_stack.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_stack.sv
// Return-address stack for call/return instructions: a push saves the caller's PC,
// a pop presents (saved PC + 1) on a registered output.
module instruction_stack #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_PC,
  input  logic                  i_call,
  input  logic                  i_rtrn,
  output logic [DATA_WIDTH-1:0] o_stack,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);

  // Request semantics: i_call/i_rtrn are single-cycle strobes sampled on each rising
  // edge; there is no back-pressure, so a request that cannot be honoured is dropped.

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] stack_q, stack_d;

  logic                  empty, full;
  logic                  do_push, do_pop, do_swap;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] top_idx;
  logic [DATA_WIDTH-1:0] top_data;

  assign empty    = (ptr_q == '0);
  assign full     = (ptr_q == PTR_FULL);
  assign top_idx  = ADDR_WIDTH'(ptr_q - PTR_ONE);
  assign top_data = mem_q[top_idx];

  // A simultaneous call+return on an empty stack has nothing to return, so it is a push.
  assign do_push = i_call && (!i_rtrn || empty) && !full;
  assign do_pop  = i_rtrn && !i_call && !empty;
  assign do_swap = i_call && i_rtrn && !empty;

  always_comb begin
    ptr_d   = ptr_q;
    stack_d = stack_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q[ADDR_WIDTH-1:0];
    if (do_push) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q[ADDR_WIDTH-1:0];
      ptr_d  = ptr_q + PTR_ONE;
    end else if (do_pop) begin
      stack_d = top_data + DATA_WIDTH'(1);
      ptr_d   = ptr_q - PTR_ONE;
    end else if (do_swap) begin
      stack_d = top_data + DATA_WIDTH'(1);
      wr_en   = 1'b1;
      wr_idx  = top_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ptr_q   <= '0;
      stack_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      stack_q <= stack_d;
    end
  end

  // Entries are left uncleared by reset: a zero pointer makes them unreachable.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= i_PC;
    end
  end

  assign o_stack = stack_q;
  assign o_empty = empty;
  assign o_full  = full;

endmodule

// File: tb/tb_instruction_stack.sv
// Bench for instruction_stack: directed scenarios plus random call/return traffic,
// checked against a queue-based return-address stack model.
module tb_instruction_stack;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] pc;
  logic          call;
  logic          rtrn;
  logic [DW-1:0] stack_out;
  logic          empty;
  logic          full;

  int tests;
  int fails;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_out;

  instruction_stack #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .i_PC    (pc),
    .i_call  (call),
    .i_rtrn  (rtrn),
    .o_stack (stack_out),
    .o_empty (empty),
    .o_full  (full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".stack"}, 32'(stack_out), 32'(model_out));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
  endtask

  // Reference behaviour of one sampled edge.
  task automatic model_step(input logic c, input logic r, input logic [DW-1:0] p);
    logic [DW-1:0] v;
    if (c && r && model_q.size() > 0) begin
      v = model_q[model_q.size()-1];
      model_out = v + 16'd1;
      model_q[model_q.size()-1] = p;
    end else if (c) begin
      if (model_q.size() < DEPTH) model_q.push_back(p);
    end else if (r) begin
      if (model_q.size() > 0) begin
        v = model_q.pop_back();
        model_out = v + 16'd1;
      end
    end
  endtask

  // driver: apply one request across one rising edge, check 1 time unit after it
  task automatic do_op(input string tag, input logic c, input logic r, input logic [DW-1:0] p);
    call = c;
    rtrn = r;
    pc   = p;
    @(posedge clk);
    model_step(c, r, p);
    #1;
    check_all(tag);
    call = 1'b0;
    rtrn = 1'b0;
  endtask

  // async reset pulse placed between clock edges
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_q.delete();
    model_out = '0;
    #1;
    check({tag, ".rst_stack"}, 32'(stack_out), 32'h0);
    check({tag, ".rst_empty"}, 32'(empty), 32'h1);
    check({tag, ".rst_full"},  32'(full),  32'h0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    model_out = '0;
    rst_n     = 1'b1;
    call      = 1'b0;
    rtrn      = 1'b0;
    pc        = '0;
    #1;
    rst_n = 1'b0;
    #3;
    check("por.stack", 32'(stack_out), 32'h0);
    check("por.empty", 32'(empty), 32'h1);
    check("por.full",  32'(full),  32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single push / pop
    do_op("r27.push", 1'b1, 1'b0, 16'd10);
    do_op("r27.pop",  1'b0, 1'b1, 16'd0);
    check("r27.const", 32'(stack_out), 32'd11);

    // nine pushes then nine pops in LIFO order
    do_reset("r28");
    for (int i = 1; i <= 9; i++) do_op("r28.push", 1'b1, 1'b0, DW'(i * 16));
    for (int i = 9; i >= 1; i--) begin
      do_op("r28.pop", 1'b0, 1'b1, 16'd0);
      check("r28.const", 32'(stack_out), 32'(i * 16 + 1));
    end

    // fill, overflow push ignored
    do_reset("r29");
    for (int i = 1; i <= DEPTH; i++) do_op("r29.push", 1'b1, 1'b0, DW'(i));
    check("r29.full", 32'(full), 32'h1);
    do_op("r29.ovf", 1'b1, 1'b0, 16'd99);
    do_op("r29.pop", 1'b0, 1'b1, 16'd0);
    check("r29.const", 32'(stack_out), 32'd17);

    // underflow pop ignored
    do_reset("r30");
    do_op("r30.upop", 1'b0, 1'b1, 16'd0);
    do_op("r30.push", 1'b1, 1'b0, 16'd5);
    do_op("r30.pop",  1'b0, 1'b1, 16'd0);
    check("r30.const", 32'(stack_out), 32'd6);

    // simultaneous call+return replaces top
    do_op("r31.push", 1'b1, 1'b0, 16'h20);
    do_op("r31.swap", 1'b1, 1'b1, 16'h30);
    check("r31.swap_const", 32'(stack_out), 32'h21);
    do_op("r31.pop",  1'b0, 1'b1, 16'h0);
    check("r31.pop_const", 32'(stack_out), 32'h31);
    do_op("r31.swap_empty", 1'b1, 1'b1, 16'h44);
    do_op("r31.pop2", 1'b0, 1'b1, 16'h0);

    // mid-sequence reset, then wrap of the +1
    for (int i = 0; i < 3; i++) do_op("r32.push", 1'b1, 1'b0, DW'(i + 7));
    do_reset("r32");
    do_op("r32.pushff", 1'b1, 1'b0, 16'hFFFF);
    do_op("r32.pop",    1'b0, 1'b1, 16'h0);
    check("r32.wrap", 32'(stack_out), 32'h0);

    // random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        do_reset("rnd");
      end else if (sel < 42) begin
        do_op("rnd.push", 1'b1, 1'b0, DW'($urandom));
      end else if (sel < 80) begin
        do_op("rnd.pop", 1'b0, 1'b1, DW'($urandom));
      end else if (sel < 90) begin
        do_op("rnd.both", 1'b1, 1'b1, DW'($urandom));
      end else begin
        do_op("rnd.idle", 1'b0, 1'b0, DW'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
